io_mmio_gpio_ctrl: RTL

- Parametrised, bit-addressed memory-mapped IO controller between the processor data bus and board IO (switches, GPIO input header, GPIO output header).
- Successor to the fixed 76-bit IO map. Adds:
  - configurable widths;
  - input synchronisers;
  - set/clear/toggle write ops on output bits;
  - sticky rising-edge flags with write-1-to-clear;
  - a registered read port with valid strobe and an address-error strobe.

---
 rtl/io_mmio_gpio_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/io_mmio_gpio_ctrl.sv
// Bit-addressed MMIO controller for switches and GPIO headers, with input synchronisers,
// sticky rising-edge flags and set/clear/toggle output ops. Optional IRQ/mask: IO_MMIO_IRQ_EN.
module io_mmio_gpio_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24,
    parameter int OUT_W  = 36,
    parameter int IN_W   = 36,
    parameter int SW_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SW_W-1:0]   switches,
    input  logic [IN_W-1:0]   gpio_in,
    output logic [OUT_W-1:0]  gpio_out,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
`ifdef IO_MMIO_IRQ_EN
    output logic              addr_err,
    output logic              irq
`else
    output logic              addr_err
`endif
);

    localparam int unsigned NE = IN_W + SW_W;
    localparam int unsigned IB = OUT_W;
    localparam int unsigned SB = IB + IN_W;
    localparam int unsigned EB = SB + SW_W;
    localparam int unsigned MB = EB + NE;
`ifdef IO_MMIO_IRQ_EN
    localparam int unsigned TOP = MB + NE;
`else
    localparam int unsigned TOP = MB;
`endif

    logic [NE-1:0]    sync1, sync2, prev, edge_flag, rise, edge_sel, edge_clr;
    logic [OUT_W-1:0] out_sel;
    logic [TOP-1:0]   map_vec, map_sh;
    logic             armed;
    logic             in_out, in_edge, in_mask, wr_ok, rd_ok;
    int unsigned      a;
    logic             unused_data;

    assign unused_data = ^data_in[DATA_W-1:3];

`ifdef IO_MMIO_IRQ_EN
    logic [NE-1:0] mask, mask_sel;
    assign map_vec = {mask, edge_flag, sync2, gpio_out};
`else
    assign map_vec = {edge_flag, sync2, gpio_out};
`endif

    always_comb begin
        a        = 32'(address);
        in_out   = (a < IB);
        in_edge  = (a >= EB) && (a < MB);
`ifdef IO_MMIO_IRQ_EN
        in_mask  = (a >= MB) && (a < TOP);
        mask_sel = NE'(1) << (a - MB);
`else
        in_mask  = 1'b0;
`endif
        wr_ok    = in_out || in_edge || in_mask;
        rd_ok    = (a < TOP);
        out_sel  = OUT_W'(1) << a;
        edge_sel = NE'(1) << (a - EB);
        edge_clr = (wr_en && in_edge && data_in[0]) ? edge_sel : '0;
        // prev is primed from sync during the first post-reset cycle without flagging
        rise     = armed ? (sync2 & ~prev) : '0;
        map_sh   = map_vec >> a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            armed     <= 1'b0;
            edge_flag <= '0;
        end else begin
            sync1     <= {switches, gpio_in};
            sync2     <= sync1;
            prev      <= sync2;
            armed     <= 1'b1;
            // a new edge wins over a coincident write-1-to-clear
            edge_flag <= (edge_flag & ~edge_clr) | rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= '0;
        end else if (wr_en && in_out) begin
            case (data_in[2:1])
                2'b00:   gpio_out <= data_in[0] ? (gpio_out | out_sel) : (gpio_out & ~out_sel);
                2'b01:   gpio_out <= gpio_out | out_sel;
                2'b10:   gpio_out <= gpio_out & ~out_sel;
                default: gpio_out <= gpio_out ^ out_sel;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            addr_err <= (wr_en && !wr_ok) || (rd_en && !rd_ok);
            if (rd_en)
                data_out <= rd_ok ? DATA_W'(map_sh[0]) : '0;
        end
    end

`ifdef IO_MMIO_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && in_mask)
                mask <= data_in[0] ? (mask | mask_sel) : (mask & ~mask_sel);
            irq <= |(edge_flag & mask);
        end
    end
`endif

endmodule
